// File: rtl/gauss_row_streamer.sv
// gauss_row_streamer: loads one matrix row at a time from an upstream
// valid/ready word stream into a row buffer, then presents the row to array
// column 0 as START + N_COLS STREAM beats. After the last row of a matrix the
// block pulses done (optionally after a DRAIN phase that unloads the array).
//
// Build option: define GAUSS_STREAMER_DRAIN_EN to enable the DRAIN state
// (N_ROWS cycles of finish_out=1 between the last element and done).
// Without it, finish_out is tied low and the last STREAM goes straight to END.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both 1; in_ready is combinational from state/hold/rst and
// does not depend on in_valid, and upstream must hold in_data/in_last
// stable while in_valid=1 and in_ready=0.
module gauss_row_streamer #(
  parameter int WIDTH  = 1,
  parameter int N_ROWS = 8,
  parameter int N_COLS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             hold,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       op_out,
  output logic             start_out,
  output logic             finish_out,
  output logic             functionA,
  output logic             first_pass,
  output logic             pass,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state_o
);

  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
`ifdef GAUSS_STREAMER_DRAIN_EN
  localparam logic [2:0] S_DRAIN  = 3'd4;
`endif
  localparam logic [2:0] S_END    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic             accept;
  logic             word_final;
  logic [WIDTH-1:0] row_buf_q [N_COLS];

  // Upstream may only transfer while loading, never under hold or reset.
  assign in_ready   = rst & ~hold & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign accept     = in_valid & in_ready;
  assign word_final = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // Next-state: row loading with in_last framing check, streaming, drain, end.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (!hold) begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (accept) begin
            if (in_last != word_final) begin
              // Framing error: drop the whole matrix and wait for a new one.
              err_d   = 1'b1;
              state_d = S_IDLE;
              col_d   = '0;
              row_d   = '0;
            end else begin
              wr_en = 1'b1;
              if (col_q == COL_LAST) begin
                col_d   = '0;
                state_d = S_START;
              end else begin
                col_d   = col_q + CW'(1);
                state_d = S_LOAD;
              end
            end
          end
        end
        S_START: state_d = S_STREAM;
        S_STREAM: begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
`ifdef GAUSS_STREAMER_DRAIN_EN
              // Row counter is reused to count the drain beats.
              row_d   = '0;
              state_d = S_DRAIN;
`else
              state_d = S_END;
`endif
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_LOAD;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
`ifdef GAUSS_STREAMER_DRAIN_EN
        S_DRAIN: begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_END;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
`endif
        S_END: begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end

  // Row buffer: data storage only, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) row_buf_q[col_q] <= in_data;
  end

  // Array-facing outputs decoded from state; zero outside START/STREAM/DRAIN.
  always_comb begin
    data_out   = '0;
    start_out  = 1'b0;
    functionA  = 1'b0;
    first_pass = 1'b0;
    finish_out = 1'b0;
    case (state_q)
      S_START: begin
        start_out  = 1'b1;
        first_pass = (row_q == '0);
      end
      S_STREAM: begin
        data_out   = row_buf_q[col_q];
        functionA  = (col_q == '0);
        first_pass = (row_q == '0);
      end
`ifdef GAUSS_STREAMER_DRAIN_EN
      S_DRAIN: finish_out = 1'b1;
`endif
      default: ;
    endcase
  end

  assign op_out      = 2'b00;
  assign pass        = 1'b0;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_END);
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gauss_row_streamer.sv
// Bench for gauss_row_streamer (2 rows x 3 columns, 4-bit elements).
// The reference model works per matrix: every accepted word is placed by its
// position in the matrix; a completed row enqueues the beats the array should
// see (start, elements, optional drain, done) into exp_q. Each cycle one beat
// is consumed unless hold froze the block on the previous edge.
module tb_gauss_row_streamer;
  localparam int WIDTH   = 4;
  localparam int N_ROWS  = 2;
  localparam int N_COLS  = 3;
  localparam int N_WORDS = N_ROWS * N_COLS;
  localparam int FW      = WIDTH + 6;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, start_out, finish_out, functionA, first_pass, pass;
  logic             busy, done, err;
  logic [WIDTH-1:0] data_out;
  logic [1:0]       op_out;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  gauss_row_streamer #(.WIDTH(WIDTH), .N_ROWS(N_ROWS), .N_COLS(N_COLS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .hold(hold),
    .data_out(data_out), .op_out(op_out), .start_out(start_out),
    .finish_out(finish_out), .functionA(functionA), .first_pass(first_pass),
    .pass(pass), .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [FW-1:0]    exp_q[$];
  logic [FW-1:0]    cur_f = '0;           // beat expected on the array this cycle
  logic [WIDTH-1:0] row_img [N_COLS];
  logic [WIDTH-1:0] mat [N_WORDS];
  int               pat032 [N_WORDS] = '{1, 0, 1, 0, 1, 1};
  int               wcnt = 0;
  bit               in_mat = 0, err_m = 0, prev_hold = 0, accepted = 0, rand_hold = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // beat = {active, start, functionA, first_pass, finish, done, data}
  function automatic logic [FW-1:0] mk(bit st, bit fa, bit fp, bit fin, bit dn, logic [WIDTH-1:0] d);
    return {1'b1, st, fa, fp, fin, dn, d};
  endfunction

  task automatic model_accept(input logic [WIDTH-1:0] d, input bit l);
    int r, c;
    bit fin;
    r   = wcnt / N_COLS;
    c   = wcnt % N_COLS;
    fin = (wcnt == N_WORDS - 1);
    if (l != fin) begin
      err_m  = 1;
      wcnt   = 0;
      in_mat = 0;
    end else begin
      row_img[c] = d;
      wcnt++;
      in_mat = 1;
      if (c == N_COLS - 1) begin
        exp_q.push_back(mk(1, 0, r == 0, 0, 0, '0));
        for (int i = 0; i < N_COLS; i++)
          exp_q.push_back(mk(0, i == 0, r == 0, 0, 0, row_img[i]));
        if (fin) begin
`ifdef GAUSS_STREAMER_DRAIN_EN
          for (int i = 0; i < N_ROWS; i++) exp_q.push_back(mk(0, 0, 0, 1, 0, '0));
`endif
          exp_q.push_back(mk(0, 0, 0, 0, 1, '0));
          wcnt   = 0;
          in_mat = 0;
        end
      end
    end
  endtask

  // Sampled on the falling edge: compare, then account for the coming edge.
  task automatic monitor();
    logic [FW-2:0] obs;
    bit exp_ready;
    obs = {start_out, functionA, first_pass, finish_out, done, data_out};
    if (!rst) begin
      exp_q.delete();
      cur_f = '0; wcnt = 0; in_mat = 0; err_m = 0; prev_hold = 0; accepted = 0;
      check("reset_outputs", obs, '0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 0);
      check("reset_err", err, 0);
      return;
    end
    if (!prev_hold) begin
      if (exp_q.size() > 0) cur_f = exp_q.pop_front();
      else cur_f = '0;
    end
    exp_ready = !hold && !cur_f[FW-1];
    check("array_outputs", obs, cur_f[FW-2:0]);
    check("busy", busy, cur_f[FW-1] | in_mat);
    check("in_ready", in_ready, exp_ready);
    check("err", err, err_m);
    check("op_pass", {op_out, pass}, 0);
    accepted  = in_valid && exp_ready;
    prev_hold = hold;
    if (accepted) model_accept(in_data, in_last);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_hold) hold = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input bit l, input int gap);
    int guard;
    guard = 0;
    in_valid = 0;
    repeat (gap) cycle();
    in_valid = 1; in_data = d; in_last = l;
    do begin
      cycle();
      guard++;
    end while (!accepted && guard < 200);
    if (!accepted) check("accept_timeout", accepted, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_matrix(input int err_pos, input int gap_lo, input int gap_hi);
    bit l;
    for (int w = 0; w < N_WORDS; w++) begin
      l = (w == N_WORDS - 1);
      if (w == err_pos) l = !l;
      send_word(mat[w], l, $urandom_range(gap_lo, gap_hi));
      if (w == err_pos) break;
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < N_WORDS; w++) mat[w] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
  endtask

  task automatic wait_quiet();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || cur_f[FW-1]) && guard < 400) begin
      cycle();
      guard++;
    end
    if (guard >= 400) check("quiet_timeout", exp_q.size(), 0);
    cycle();
    cycle();
  endtask

  // Called right after a rising edge; reset lands mid-cycle.
  task automatic do_reset_async();
    #2;
    rst = 0;
    #1;
    check("async_outputs", {start_out, functionA, first_pass, finish_out, done, data_out}, '0);
    check("async_busy", busy, 0);
    check("async_in_ready", in_ready, 0);
    check("async_err", err, 0);
    in_valid = 0; hold = 0;
    cycle();
    cycle();
    rst = 1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1 rst = 0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1;
    cycle();

    // Reference matrix 1,0,1 / 0,1,1
    for (int w = 0; w < N_WORDS; w++) mat[w] = WIDTH'(pat032[w]);
    send_matrix(-1, 0, 0);
    wait_quiet();

    // Hold for 3 cycles while element 1 of row 0 is on the array
    fill_random();
    for (int w = 0; w < N_COLS; w++) send_word(mat[w], 0, 0);
    cycle();
    cycle();
    hold = 1;
    repeat (3) cycle();
    hold = 0;
    for (int w = N_COLS; w < N_WORDS; w++) send_word(mat[w], w == N_WORDS - 1, 0);
    wait_quiet();

    // One word every third cycle
    fill_random();
    send_matrix(-1, 2, 2);
    wait_quiet();

    // in_last on word 4: error, matrix discarded, err sticky
    fill_random();
    send_matrix(3, 0, 0);
    repeat (5) cycle();
    fill_random();
    send_matrix(-1, 0, 1);
    wait_quiet();

    // Reset clears err; then reset in the middle of row 1 streaming
    do_reset_async();
    fill_random();
    send_matrix(-1, 0, 0);
    cycle();
    cycle();
    do_reset_async();
    fill_random();
    send_matrix(-1, 0, 0);
    wait_quiet();

    // Randomized traffic: gaps, hold and occasional framing errors
    rand_hold = 1;
    for (int m = 0; m < 40; m++) begin
      fill_random();
      if ($urandom_range(0, 5) == 0) send_matrix($urandom_range(0, N_WORDS - 1), 0, 2);
      else send_matrix(-1, 0, 2);
    end
    rand_hold = 0;
    hold = 0;
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
